// File: rtl/ddr_frame_writer_pkg.sv
// ============================================================================
// Module  : ddr_frame_writer_pkg
// Purpose : DDR geometry, frame geometry and writer state encoding.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ddr_frame_writer_pkg;

    localparam int CTRL_ADDR_WIDTH = 28;
    localparam int MEM_DQ_WIDTH    = 32;
    localparam int DDR_DATA_WIDTH  = MEM_DQ_WIDTH * 8;
    localparam int MAX_MEM_LOC     = 1 << CTRL_ADDR_WIDTH;

    localparam int H_ACTIVE        = 1920;
    localparam int V_ACTIVE        = 1080;
    localparam int PIXEL_WIDTH     = 24;
    localparam int PIX_PER_WORD    = 10;
    localparam int FRAME_WORDS     = (H_ACTIVE * V_ACTIVE) / PIX_PER_WORD;

    localparam int PACK_CNT_W      = 4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PACK      = 3'd1,
        ST_REQ       = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_WAIT_DONE = 3'd4
    } fw_state_e;

endpackage

`default_nettype wire

// File: rtl/ddr_frame_writer_pixel_packer.sv
// ============================================================================
// Module  : ddr_frame_writer_pixel_packer
// Purpose : Drains the pixel FIFO and shifts 10 pixels into one DDR word.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ddr_frame_writer_pixel_packer
    import ddr_frame_writer_pkg::*;
#(
    parameter int PIX_W  = PIXEL_WIDTH,
    parameter int DATA_W = DDR_DATA_WIDTH
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              fifo_empty_i,
    input  logic [PIX_W-1:0]  fifo_rdata_i,
    output logic              fifo_rd_en_o,
    output logic [DATA_W-1:0] word_o,
    output logic              full_o
);

    localparam int PACK_W = PIX_W * PIX_PER_WORD;

    logic [PACK_CNT_W-1:0] issued_q;
    logic [PACK_CNT_W-1:0] landed_q;
    logic                  ret_q;
    logic [PACK_W-1:0]     word_q;

    // Strobes are blocked during a flush so no pixel is popped and then lost.
    assign fifo_rd_en_o = !flush_i && !fifo_empty_i &&
                          (issued_q < PACK_CNT_W'(PIX_PER_WORD));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            issued_q <= '0;
            landed_q <= '0;
            ret_q    <= 1'b0;
            word_q   <= '0;
        end else if (flush_i) begin
            // The word itself is held: it is the write data while a write is open.
            issued_q <= '0;
            landed_q <= '0;
            ret_q    <= 1'b0;
        end else begin
            ret_q <= fifo_rd_en_o;
            if (fifo_rd_en_o) begin
                issued_q <= issued_q + PACK_CNT_W'(1);
            end
            if (ret_q) begin
                word_q   <= {fifo_rdata_i, word_q[PACK_W-1:PIX_W]};
                landed_q <= landed_q + PACK_CNT_W'(1);
            end
        end
    end

    assign full_o = (landed_q == PACK_CNT_W'(PIX_PER_WORD));
    assign word_o = DATA_W'(word_q);

endmodule

`default_nettype wire

// File: rtl/ddr_frame_writer.sv
// ============================================================================
// Module  : ddr_frame_writer
// Purpose : Packs FIFO pixels into DDR words and issues frame-linear writes.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ddr_frame_writer
    import ddr_frame_writer_pkg::*;
#(
    parameter int                ADDR_W      = CTRL_ADDR_WIDTH,
    parameter int                DATA_W      = DDR_DATA_WIDTH,
    parameter int                PIX_W       = PIXEL_WIDTH,
    parameter int                FRAME_WORDS = ddr_frame_writer_pkg::FRAME_WORDS,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                ADDR_STEP   = 32
) (
    input  logic              ddr_clk_i,
    input  logic              rst_i,
    input  logic              init_done_i,
    input  logic              frame_start_i,
    input  logic              fifo_empty_i,
    output logic              fifo_rd_en_o,
    input  logic [PIX_W-1:0]  fifo_rdata_i,
    output logic              wr_req_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [DATA_W-1:0] wr_data_o,
    output logic [3:0]        awlen_o,
    input  logic              wr_busy_i,
    input  logic              wr_done_i,
    output logic              frame_done_o
);

    localparam int IDX_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

    fw_state_e         state_q;
    logic              wr_req_q;
    logic              frame_done_q;
    logic              resync_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [IDX_W-1:0]  word_idx_q;

    logic w_flush;
    logic w_full;
    logic w_realign;
    logic w_last;

    // Packer counts are only live in PACK; a frame_start there drops the partial word.
    assign w_flush   = rst_i || (state_q != ST_PACK) || frame_start_i;
    assign w_realign = resync_q || frame_start_i;
    assign w_last    = (word_idx_q == IDX_W'(FRAME_WORDS - 1));

    ddr_frame_writer_pixel_packer #(
        .PIX_W  (PIX_W),
        .DATA_W (DATA_W)
    ) u_packer (
        .clk_i        (ddr_clk_i),
        .rst_i        (rst_i),
        .flush_i      (w_flush),
        .fifo_empty_i (fifo_empty_i),
        .fifo_rdata_i (fifo_rdata_i),
        .fifo_rd_en_o (fifo_rd_en_o),
        .word_o       (wr_data_o),
        .full_o       (w_full)
    );

    always_ff @(posedge ddr_clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            wr_req_q     <= 1'b0;
            frame_done_q <= 1'b0;
            resync_q     <= 1'b0;
            wr_addr_q    <= BASE_ADDR;
            word_idx_q   <= '0;
        end else begin
            wr_req_q     <= 1'b0;
            frame_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (init_done_i && frame_start_i) begin
                        state_q    <= ST_PACK;
                        wr_addr_q  <= BASE_ADDR;
                        word_idx_q <= '0;
                        resync_q   <= 1'b0;
                    end
                end
                ST_PACK: begin
                    if (frame_start_i) begin
                        wr_addr_q  <= BASE_ADDR;
                        word_idx_q <= '0;
                    end else if (!init_done_i) begin
                        state_q <= ST_IDLE;
                    end else if (w_full) begin
                        state_q  <= ST_REQ;
                        wr_req_q <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (frame_start_i) begin
                        resync_q <= 1'b1;
                    end
                    state_q <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY, ST_WAIT_DONE: begin
                    if (wr_done_i) begin
                        resync_q <= 1'b0;
                        state_q  <= init_done_i ? ST_PACK : ST_IDLE;
                        // A pending realign overrides both increment and end-of-frame.
                        if (w_realign || w_last) begin
                            wr_addr_q    <= BASE_ADDR;
                            word_idx_q   <= '0;
                            frame_done_q <= !w_realign;
                        end else begin
                            wr_addr_q  <= wr_addr_q + ADDR_W'(ADDR_STEP);
                            word_idx_q <= word_idx_q + IDX_W'(1);
                        end
                    end else begin
                        if (frame_start_i) begin
                            resync_q <= 1'b1;
                        end
                        if ((state_q == ST_WAIT_BUSY) && wr_busy_i) begin
                            state_q <= ST_WAIT_DONE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign wr_req_o     = wr_req_q;
    assign wr_addr_o    = wr_addr_q;
    assign frame_done_o = frame_done_q;
    assign awlen_o      = 4'd0;

endmodule

`default_nettype wire

// File: tb/tb_ddr_frame_writer.sv
// ============================================================================
// Module  : tb_ddr_frame_writer
// Purpose : Scoreboard bench for ddr_frame_writer with a 4-word frame.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ddr_frame_writer;

    localparam int FW = 4;

    typedef struct packed {
        logic [27:0]  addr;
        logic [255:0] data;
    } wr_t;

    logic         clk         = 1'b0;
    logic         rst         = 1'b1;
    logic         init_done   = 1'b0;
    logic         frame_start = 1'b0;
    logic         wr_busy     = 1'b0;
    logic         wr_done     = 1'b0;
    logic [23:0]  fifo_rdata  = '0;
    logic         fifo_empty;
    logic         fifo_rd_en;
    logic         wr_req;
    logic [27:0]  wr_addr;
    logic [255:0] wr_data;
    logic [3:0]   awlen;
    logic         frame_done;

    int n_cmp   = 0;
    int n_err   = 0;
    int req_cnt = 0;
    int fd_cnt  = 0;
    int served  = 0;
    int rd_ptr  = 0;
    int wr_ptr  = 0;

    logic [23:0]  pix_mem [0:255];
    logic [239:0] acc   = '0;
    int           acc_n = 0;
    wr_t          exp_q [$];

    always #5 clk = ~clk;

    ddr_frame_writer #(
        .FRAME_WORDS (FW)
    ) dut (
        .ddr_clk_i     (clk),
        .rst_i         (rst),
        .init_done_i   (init_done),
        .frame_start_i (frame_start),
        .fifo_empty_i  (fifo_empty),
        .fifo_rd_en_o  (fifo_rd_en),
        .fifo_rdata_i  (fifo_rdata),
        .wr_req_o      (wr_req),
        .wr_addr_o     (wr_addr),
        .wr_data_o     (wr_data),
        .awlen_o       (awlen),
        .wr_busy_i     (wr_busy),
        .wr_done_i     (wr_done),
        .frame_done_o  (frame_done)
    );

    // Show-ahead-free FIFO model: data appears the cycle after the strobe.
    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_rdata <= pix_mem[rd_ptr[7:0]];
            rd_ptr     <= rd_ptr + 1;
        end
        if (wr_req)     req_cnt <= req_cnt + 1;
        if (frame_done) fd_cnt  <= fd_cnt + 1;
    end

    task automatic tb_check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_pix(input logic [23:0] p);
        @(negedge clk);
        pix_mem[wr_ptr[7:0]] = p;
        wr_ptr++;
        acc[acc_n*24 +: 24] = p;
        acc_n++;
    endtask

    task automatic push_n(input int n, input logic [23:0] base);
        for (int k = 0; k < n; k++) push_pix(base + 24'(k));
    endtask

    task automatic expect_word(input logic [27:0] a);
        exp_q.push_back({a, 16'h0000, acc});
        acc_n = 0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Acts as axi_ctrl for one write; optionally injects frame_start or rst in WAIT_DONE.
    task automatic serve_write(input bit fs_in_wait, input bit rst_in_wait);
        int  t;
        wr_t e;
        t = 0;
        while ((req_cnt == served) && (t < 300)) begin
            @(negedge clk);
            t++;
        end
        if (req_cnt == served) begin
            tb_check("wr_req_timeout", 256'(req_cnt), 256'(served + 1));
            return;
        end
        served++;
        if (exp_q.size() == 0) begin
            tb_check("sb_unexpected_write", 256'(exp_q.size()), 256'(1));
            e = '0;
        end else begin
            e = exp_q.pop_front();
        end
        tb_check("wr_addr", 256'(wr_addr), 256'(e.addr));
        tb_check("wr_data", wr_data, e.data);
        tb_check("awlen", 256'(awlen), 256'(0));
        @(negedge clk);
        wr_busy = 1'b1;
        tb_check("wr_req_single", 256'(wr_req), 256'(0));
        @(negedge clk);
        if (fs_in_wait) begin
            frame_start = 1'b1;
            @(negedge clk);
            frame_start = 1'b0;
        end
        if (rst_in_wait) begin
            rst     = 1'b1;
            wr_busy = 1'b0;
            @(negedge clk);
            rst     = 1'b0;
            wr_done = 1'b1;
            @(negedge clk);
            wr_done = 1'b0;
            return;
        end
        tb_check("wr_data_hold", wr_data, e.data);
        wr_busy = 1'b0;
        wr_done = 1'b1;
        @(negedge clk);
        wr_done = 1'b0;
    endtask

    initial begin
        // Reset with init_done low.
        wait_cycles(3);
        tb_check("rst_wr_req", 256'(wr_req), 256'(0));
        tb_check("rst_wr_addr", 256'(wr_addr), 256'(0));
        tb_check("rst_wr_data", wr_data, 256'(0));
        tb_check("rst_frame_done", 256'(frame_done), 256'(0));
        tb_check("rst_rd_en", 256'(fifo_rd_en), 256'(0));
        tb_check("rst_awlen", 256'(awlen), 256'(0));
        rst = 1'b0;

        // Pixels wait in the FIFO until init_done and frame_start.
        push_n(10, 24'h144475);
        for (int k = 0; k < 10; k++) acc[k*24 +: 24] = 24'h144475;
        pix_mem[0:9] = '{default: 24'h144475};
        wait_cycles(5);
        tb_check("idle_no_read", 256'(rd_ptr), 256'(0));
        expect_word(28'h0000000);

        init_done   = 1'b1;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        serve_write(1'b0, 1'b0);
        tb_check("next_addr", 256'(wr_addr), 256'(28'h20));

        // FIFO runs dry after 4 pixels.
        push_n(4, 24'hA00000);
        wait_cycles(20);
        tb_check("no_req_partial", 256'(req_cnt), 256'(served));
        push_n(6, 24'hA00004);
        expect_word(28'h20);
        serve_write(1'b0, 1'b0);

        // Rest of the 4-word frame, then wrap.
        push_n(10, 24'hB00000);
        expect_word(28'h40);
        push_n(10, 24'hB10000);
        expect_word(28'h60);
        serve_write(1'b0, 1'b0);
        serve_write(1'b0, 1'b0);
        @(negedge clk);
        tb_check("frame_done_cnt", 256'(fd_cnt), 256'(1));
        push_n(10, 24'hB20000);
        expect_word(28'h00);
        serve_write(1'b0, 1'b0);

        // frame_start during PACK drops the partial word.
        push_n(6, 24'hC00000);
        wait_cycles(5);
        tb_check("partial_consumed", 256'(rd_ptr), 256'(wr_ptr));
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        acc_n = 0;
        push_n(10, 24'hC10000);
        expect_word(28'h00);
        serve_write(1'b0, 1'b0);

        // frame_start during WAIT_DONE realigns the following write.
        push_n(10, 24'hD00000);
        expect_word(28'h20);
        push_n(10, 24'hD10000);
        expect_word(28'h00);
        serve_write(1'b1, 1'b0);
        serve_write(1'b0, 1'b0);
        @(negedge clk);
        tb_check("no_frame_done_realign", 256'(fd_cnt), 256'(1));

        // rst in WAIT_DONE, then a stray wr_done.
        push_n(10, 24'hE00000);
        expect_word(28'h20);
        serve_write(1'b0, 1'b1);
        wait_cycles(20);
        tb_check("post_rst_no_req", 256'(req_cnt), 256'(served));
        tb_check("post_rst_wr_req", 256'(wr_req), 256'(0));
        tb_check("post_rst_addr", 256'(wr_addr), 256'(0));
        tb_check("post_rst_data", wr_data, 256'(0));
        tb_check("post_rst_frame_done", 256'(fd_cnt), 256'(1));
        push_n(3, 24'hF00000);
        wait_cycles(5);
        tb_check("post_rst_idle", 256'(wr_ptr - rd_ptr), 256'(3));
        tb_check("sb_drained", 256'(exp_q.size()), 256'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

`default_nettype wire
